// File: rtl/adc_spi_sched.sv
// adc_spi_sched: arbitrates one SPI master between data-read frames from the
// sampling FSM and three-frame register accesses (enter config mode, access,
// exit config mode). Reads win over config; reads that arrive while the bus is
// busy are dropped and counted. Every wait for the SPI is bounded by a timeout.
module adc_spi_sched #(
   parameter int          P_TIMEOUT = 1000,
   parameter logic [23:0] P_ENTER   = 24'hBF_FF00,
   parameter logic [23:0] P_EXIT    = 24'h00_1401
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rd_req,
   output logic        o_rd_done,
   output logic        o_rd_drop,
   output logic [7:0]  o_drop_cnt,
   input  logic        i_cfg_req,
   input  logic        i_cfg_wr,
   input  logic [14:0] i_cfg_addr,
   input  logic [7:0]  i_cfg_wdata,
   output logic        o_cfg_busy,
   output logic        o_cfg_done,
   output logic        o_cfg_err,
   output logic [7:0]  o_cfg_rdata,
   output logic        o_spi_start,
   output logic        o_spi_mode,
   output logic [23:0] o_spi_tx,
   input  logic        i_spi_done,
   input  logic [7:0]  i_spi_rx,
   output logic        o_timeout,
   output logic [3:0]  o_state
);

   localparam int CW = $clog2(P_TIMEOUT + 1);

   typedef enum logic [3:0] {
      RST_EXIT  = 4'd0,
      RST_WAIT  = 4'd1,
      IDLE      = 4'd2,
      RD_START  = 4'd3,
      RD_WAIT   = 4'd4,
      ENT_START = 4'd5,
      ENT_WAIT  = 4'd6,
      ACC_START = 4'd7,
      ACC_WAIT  = 4'd8,
      EXT_START = 4'd9,
      EXT_WAIT  = 4'd10,
      CFG_END   = 4'd11
   } state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  wait_cnt;
   logic           in_wait;
   logic           tmo_hit;
   logic           start_nx;
   logic           mode_nx;
   logic [23:0]    tx_nx;
   logic [23:0]    acc_frame;
   logic           dropped;

   // latched config request
   logic           busy_q;
   logic           wr_q;
   logic [14:0]    addr_q;
   logic [7:0]     wdata_q;

   // registered outputs / status
   logic           start_q;
   logic           mode_q;
   logic [23:0]    tx_q;
   logic           rd_fin;
   logic           rd_done_q;
   logic           drop_q;
   logic [7:0]     drop_cnt_q;
   logic           err_q;
   logic [7:0]     rdata_q;

   assign in_wait   = state inside {RST_WAIT, RD_WAIT, ENT_WAIT, ACC_WAIT, EXT_WAIT};
   // done on the same cycle as the last counted cycle takes precedence
   assign tmo_hit   = in_wait && !i_spi_done && (wait_cnt == CW'(P_TIMEOUT - 1));
   assign acc_frame = {~wr_q, addr_q, (wr_q ? wdata_q : 8'h00)};
   assign dropped   = i_rd_req && (state != IDLE);

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= RST_EXIT;
      else       state <= state_nx;
   end

   // next state plus the frame to launch when entering a start state
   always_comb begin
      state_nx = state;
      start_nx = 1'b0;
      mode_nx  = 1'b0;
      tx_nx    = '0;
      case (state)
         // the exit frame launches as we leave, so tx is valid with start
         RST_EXIT: begin
            state_nx = RST_WAIT;
            start_nx = 1'b1;
            mode_nx  = 1'b1;
            tx_nx    = P_EXIT;
         end
         RST_WAIT: begin
            if (i_spi_done || tmo_hit) state_nx = IDLE;
         end
         IDLE: begin
            if (i_rd_req) begin
               state_nx = RD_START;
               start_nx = 1'b1;
            end else if (busy_q) begin
               state_nx = ENT_START;
               start_nx = 1'b1;
               mode_nx  = 1'b1;
               tx_nx    = P_ENTER;
            end
         end
         RD_START:  state_nx = RD_WAIT;
         RD_WAIT: begin
            if (i_spi_done || tmo_hit) state_nx = IDLE;
         end
         ENT_START: state_nx = ENT_WAIT;
         ENT_WAIT: begin
            if (i_spi_done) begin
               state_nx = ACC_START;
               start_nx = 1'b1;
               mode_nx  = 1'b1;
               tx_nx    = acc_frame;
            end else if (tmo_hit) begin
               // skip the access but still leave config mode
               state_nx = EXT_START;
               start_nx = 1'b1;
               mode_nx  = 1'b1;
               tx_nx    = P_EXIT;
            end
         end
         ACC_START: state_nx = ACC_WAIT;
         ACC_WAIT: begin
            if (i_spi_done || tmo_hit) begin
               state_nx = EXT_START;
               start_nx = 1'b1;
               mode_nx  = 1'b1;
               tx_nx    = P_EXIT;
            end
         end
         EXT_START: state_nx = EXT_WAIT;
         EXT_WAIT: begin
            if (i_spi_done || tmo_hit) state_nx = CFG_END;
         end
         CFG_END:   state_nx = IDLE;
         default:   state_nx = RST_EXIT;
      endcase
   end

   // SPI launch registers and wait counter; tx/mode only change on a launch
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         start_q  <= 1'b0;
         mode_q   <= 1'b0;
         tx_q     <= '0;
         wait_cnt <= '0;
      end else begin
         start_q <= start_nx;
         if (start_nx) begin
            mode_q <= mode_nx;
            tx_q   <= tx_nx;
         end
         if (state_nx != state) wait_cnt <= '0;
         else if (in_wait)      wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // read completion, drop accounting
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_fin     <= 1'b0;
         rd_done_q  <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         rd_fin    <= (state == RD_WAIT) && i_spi_done;
         rd_done_q <= rd_fin;
         drop_q    <= dropped;
         if (dropped && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   // config request latch, error flag and read-data capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         // busy drops as CFG_END is entered so it is low alongside cfg_done
         if (state_nx == CFG_END) begin
            busy_q <= 1'b0;
         end else if (!busy_q && i_cfg_req) begin
            busy_q  <= 1'b1;
            wr_q    <= i_cfg_wr;
            addr_q  <= i_cfg_addr;
            wdata_q <= i_cfg_wdata;
         end
         // a timeout anywhere in the sequence is reported at CFG_END
         if (state == CFG_END)
            err_q <= 1'b0;
         else if (tmo_hit && (state inside {ENT_WAIT, ACC_WAIT, EXT_WAIT}))
            err_q <= 1'b1;
         if ((state == ACC_WAIT) && i_spi_done && !wr_q) rdata_q <= i_spi_rx;
      end
   end

   assign o_spi_start = start_q;
   assign o_spi_mode  = mode_q;
   assign o_spi_tx    = tx_q;
   assign o_rd_done   = rd_done_q;
   assign o_rd_drop   = drop_q;
   assign o_drop_cnt  = drop_cnt_q;
   assign o_cfg_busy  = busy_q;
   assign o_cfg_done  = (state == CFG_END);
   assign o_cfg_err   = err_q && (state == CFG_END);
   assign o_cfg_rdata = rdata_q;
   assign o_timeout   = tmo_hit;
   assign o_state     = state;

endmodule

// File: tb/tb_adc_spi_sched.sv
// Testbench for adc_spi_sched: acts as the SPI engine, the sampling FSM and the
// register-access client; checks frames, timing and status against values
// derived from the block's rules.
module tb_adc_spi_sched;
   localparam int          TMO = 64;
   localparam logic [23:0] ENT = 24'hBF_FF00;
   localparam logic [23:0] EXT = 24'h00_1401;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_rd_req = 1'b0, i_cfg_req = 1'b0, i_cfg_wr = 1'b0;
   logic [14:0] i_cfg_addr = '0;
   logic [7:0]  i_cfg_wdata = '0, i_spi_rx = '0;
   logic        i_spi_done = 1'b0;
   logic        o_rd_done, o_rd_drop, o_cfg_busy, o_cfg_done, o_cfg_err;
   logic        o_spi_start, o_spi_mode, o_timeout;
   logic [7:0]  o_drop_cnt, o_cfg_rdata;
   logic [23:0] o_spi_tx;
   logic [3:0]  o_state;

   int          cyc = 0;
   int          n_chk = 0, n_err = 0;
   int          drops_m = 0;
   logic [7:0]  rdata_m = '0;

   typedef struct {
      logic        wr;
      logic [14:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rx;
      int          lat;
      int          drop_at;
      logic [23:0] exp_acc;
      logic [7:0]  exp_rdata;
   } vec_t;
   vec_t tv[6];

   adc_spi_sched #(.P_TIMEOUT(TMO), .P_ENTER(ENT), .P_EXIT(EXT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rd_req(i_rd_req), .o_rd_done(o_rd_done), .o_rd_drop(o_rd_drop),
      .o_drop_cnt(o_drop_cnt),
      .i_cfg_req(i_cfg_req), .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr),
      .i_cfg_wdata(i_cfg_wdata), .o_cfg_busy(o_cfg_busy), .o_cfg_done(o_cfg_done),
      .o_cfg_err(o_cfg_err), .o_cfg_rdata(o_cfg_rdata),
      .o_spi_start(o_spi_start), .o_spi_mode(o_spi_mode), .o_spi_tx(o_spi_tx),
      .i_spi_done(i_spi_done), .i_spi_rx(i_spi_rx),
      .o_timeout(o_timeout), .o_state(o_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int sat255(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic logic sig(input int sel);
      case (sel)
         0: return o_spi_start;
         1: return o_rd_done;
         2: return o_cfg_done;
         3: return o_timeout;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // polls at negedges, current cycle first
   task automatic wait_sig(input int sel, input int bound, input string nm);
      int k = 0;
      while (!sig(sel) && k < bound) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (!sig(sel)) begin
         n_err++;
         $display("FAIL %s: no event within %0d cycles", nm, bound);
      end
   endtask

   // SPI engine: wait for a launch, answer with done 'lat' cycles after the
   // start cycle; optionally fire a read request at offset drop_at
   task automatic serve(input int lat, input logic [7:0] rx, input int drop_at,
                        input string nm, output logic [23:0] tx, output logic mode,
                        output int t0, output logic drop_seen);
      wait_sig(0, 200, {nm, "_start"});
      tx = o_spi_tx;
      mode = o_spi_mode;
      t0 = cyc;
      drop_seen = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) chk({nm, "_start_width"}, o_spi_start, 1'b0);
         if (drop_at > 0 && k == drop_at + 1) drop_seen = o_rd_drop;
         i_rd_req = (k == drop_at);
         if (k == lat) begin
            chk({nm, "_tx_stable"}, o_spi_tx, tx);
            i_spi_done = 1'b1;
            i_spi_rx = rx;
         end
      end
      @(negedge clk);
      i_spi_done = 1'b0;
      i_rd_req = 1'b0;
   endtask

   task automatic run_rd(input int lat, input string nm);
      logic [23:0] tx; logic md, ds; int t0;
      i_rd_req = 1'b1;
      @(negedge clk);
      i_rd_req = 1'b0;
      serve(lat, 8'($urandom), 0, nm, tx, md, t0, ds);
      chk({nm, "_tx"}, tx, 24'h0);
      chk({nm, "_mode"}, md, 1'b0);
      wait_sig(1, 5, {nm, "_rd_done"});
      chk({nm, "_rd_latency"}, cyc - t0, lat + 2);
      @(negedge clk);
   endtask

   task automatic run_cfg(input logic wr, input logic [14:0] addr, input logic [7:0] wd,
                          input logic [7:0] rx, input int lat, input int drop_at,
                          input logic [23:0] exp_acc, input logic [7:0] exp_rd,
                          input string nm);
      logic [23:0] tx; logic md, ds; int t0;
      i_cfg_req = 1'b1; i_cfg_wr = wr; i_cfg_addr = addr; i_cfg_wdata = wd;
      @(negedge clk);
      // scramble the request bus: the DUT must use its latched copy
      i_cfg_req = 1'b0; i_cfg_wr = ~wr; i_cfg_addr = ~addr; i_cfg_wdata = ~wd;
      chk({nm, "_busy"}, o_cfg_busy, 1'b1);
      serve(lat, ~rx, 0, {nm, "_ent"}, tx, md, t0, ds);
      chk({nm, "_ent_tx"}, tx, ENT);
      chk({nm, "_ent_mode"}, md, 1'b1);
      serve(lat, rx, drop_at, {nm, "_acc"}, tx, md, t0, ds);
      chk({nm, "_acc_tx"}, tx, exp_acc);
      chk({nm, "_acc_mode"}, md, 1'b1);
      if (drop_at > 0) begin
         drops_m++;
         chk({nm, "_drop_pulse"}, ds, 1'b1);
      end
      serve(lat, ~rx, 0, {nm, "_ext"}, tx, md, t0, ds);
      chk({nm, "_ext_tx"}, tx, EXT);
      chk({nm, "_ext_mode"}, md, 1'b1);
      wait_sig(2, 5, {nm, "_cfg_done"});
      chk({nm, "_err"}, o_cfg_err, 1'b0);
      chk({nm, "_busy_clr"}, o_cfg_busy, 1'b0);
      chk({nm, "_rdata"}, o_cfg_rdata, exp_rd);
      chk({nm, "_drop_cnt"}, o_drop_cnt, sat255(drops_m));
      @(negedge clk);
      chk({nm, "_idle"}, o_state, 4'd2);
   endtask

   initial begin
      logic [23:0] tx; logic md, ds; int t0;
      logic wr; logic [14:0] addr; logic [7:0] wd, rx; int lat, dat;
      logic [23:0] exp_acc;

      tv[0] = '{1'b0, 15'h0020, 8'h55, 8'h80, 12, 0, 24'h80_2000, 8'h80};
      tv[1] = '{1'b1, 15'h1234, 8'hA5, 8'h3C,  5, 0, 24'h12_34A5, 8'h80};
      tv[2] = '{1'b0, 15'h7FFF, 8'h12, 8'hFF,  7, 0, 24'hFF_FF00, 8'hFF};
      tv[3] = '{1'b1, 15'h0000, 8'h00, 8'h11,  9, 2, 24'h00_0000, 8'hFF};
      tv[4] = '{1'b0, 15'h4001, 8'hEE, 8'h00,  4, 0, 24'hC0_0100, 8'h00};
      tv[5] = '{1'b1, 15'h0155, 8'h7E, 8'h5A,  6, 0, 24'h01_557E, 8'h00};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_state", o_state, 4'd0);
      chk("rst_start", o_spi_start, 1'b0);
      chk("rst_busy", o_cfg_busy, 1'b0);
      chk("rst_tx", o_spi_tx, 24'h0);
      chk("rst_mode", o_spi_mode, 1'b0);
      chk("rst_drop_cnt", o_drop_cnt, 8'h0);
      chk("rst_rdata", o_cfg_rdata, 8'h0);
      rst = 1'b0;

      // exit frame after reset
      serve(30, 8'h00, 0, "boot", tx, md, t0, ds);
      chk("boot_tx", tx, EXT);
      chk("boot_mode", md, 1'b1);
      chk("boot_idle", o_state, 4'd2);
      chk("boot_no_restart", o_spi_start, 1'b0);

      // read latency
      run_rd(25, "rd25");

      // read and config in the same cycle; read drop during the access
      i_rd_req = 1'b1; i_cfg_req = 1'b1; i_cfg_wr = 1'b0; i_cfg_addr = 15'h0010;
      @(negedge clk);
      i_rd_req = 1'b0; i_cfg_req = 1'b0;
      serve(8, 8'h00, 0, "pri_rd", tx, md, t0, ds);
      chk("pri_rd_first_mode", md, 1'b0);
      chk("pri_rd_first_tx", tx, 24'h0);
      serve(8, 8'h00, 0, "pri_ent", tx, md, t0, ds);
      chk("pri_ent_tx", tx, ENT);
      serve(8, 8'h6B, 3, "pri_acc", tx, md, t0, ds);
      chk("pri_acc_tx", tx, 24'h80_1000);
      drops_m++;
      chk("pri_drop_pulse", ds, 1'b1);
      serve(8, 8'h00, 0, "pri_ext", tx, md, t0, ds);
      chk("pri_ext_tx", tx, EXT);
      wait_sig(2, 5, "pri_cfg_done");
      chk("pri_rdata", o_cfg_rdata, 8'h6B);
      chk("pri_drop_cnt", o_drop_cnt, 8'd1);
      @(negedge clk);

      // table of config accesses
      for (int i = 0; i < 6; i++) begin
         run_cfg(tv[i].wr, tv[i].addr, tv[i].wd, tv[i].rx, tv[i].lat, tv[i].drop_at,
                 tv[i].exp_acc, tv[i].exp_rdata, $sformatf("tv%0d", i));
         rdata_m = tv[i].exp_rdata;
      end

      // timeout in the access frame
      i_cfg_req = 1'b1; i_cfg_wr = 1'b1; i_cfg_addr = 15'h0042; i_cfg_wdata = 8'h99;
      @(negedge clk);
      i_cfg_req = 1'b0;
      serve(6, 8'h00, 0, "to_ent", tx, md, t0, ds);
      chk("to_ent_tx", tx, ENT);
      wait_sig(0, 200, "to_acc_start");
      chk("to_acc_tx", o_spi_tx, 24'h00_4299);
      t0 = cyc;
      wait_sig(3, TMO + 10, "to_timeout");
      chk("to_timeout_time", cyc - t0, TMO);
      chk("to_timeout_state", o_state, 4'd8);
      @(negedge clk);
      chk("to_ext_state", o_state, 4'd9);
      chk("to_ext_start", o_spi_start, 1'b1);
      chk("to_pulse_width", o_timeout, 1'b0);
      serve(6, 8'h00, 0, "to_ext", tx, md, t0, ds);
      chk("to_ext_tx", tx, EXT);
      wait_sig(2, 5, "to_cfg_done");
      chk("to_err", o_cfg_err, 1'b1);
      chk("to_rdata_kept", o_cfg_rdata, rdata_m);
      @(negedge clk);

      // randomized traffic against the model
      for (int i = 0; i < 16; i++) begin
         lat = $urandom_range(3, 20);
         if ($urandom_range(0, 2) == 0) begin
            run_rd(lat, $sformatf("rnd%0d_rd", i));
         end else begin
            wr   = 1'($urandom_range(0, 1));
            addr = 15'($urandom);
            wd   = 8'($urandom);
            rx   = 8'($urandom);
            dat  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 1) : 0;
            exp_acc = 24'((wr ? 0 : 32'h80_0000) + int'(addr) * 256 + (wr ? int'(wd) : 0));
            if (!wr) rdata_m = rx;
            run_cfg(wr, addr, wd, rx, lat, dat, exp_acc, rdata_m, $sformatf("rnd%0d_cfg", i));
         end
      end

      // drop counter saturation: hold read request through six reads
      for (int r = 0; r < 6; r++) begin
         i_rd_req = 1'b1;
         @(negedge clk);
         for (int k = 0; k < 50; k++) begin
            drops_m++;
            @(negedge clk);
         end
         i_rd_req = 1'b0;
         i_spi_done = 1'b1;
         @(negedge clk);
         i_spi_done = 1'b0;
         repeat (3) @(negedge clk);
         chk($sformatf("sat_drop_cnt%0d", r), o_drop_cnt, sat255(drops_m));
      end
      chk("sat_drop_cnt_final", o_drop_cnt, 8'd255);

      // reset in the middle of the access frame
      i_cfg_req = 1'b1; i_cfg_wr = 1'b0; i_cfg_addr = 15'h0033;
      @(negedge clk);
      i_cfg_req = 1'b0;
      serve(5, 8'h00, 0, "mr_ent", tx, md, t0, ds);
      wait_sig(0, 200, "mr_acc_start");
      repeat (4) @(negedge clk);
      chk("mr_in_acc_wait", o_state, 4'd8);
      rst = 1'b1;
      #1;
      chk("mr_busy", o_cfg_busy, 1'b0);
      chk("mr_state", o_state, 4'd0);
      chk("mr_drop_cnt", o_drop_cnt, 8'd0);
      chk("mr_rdata", o_cfg_rdata, 8'd0);
      chk("mr_tx", o_spi_tx, 24'h0);
      @(negedge clk);
      rst = 1'b0;
      serve(10, 8'h00, 0, "mr_boot", tx, md, t0, ds);
      chk("mr_boot_tx", tx, EXT);
      chk("mr_boot_mode", md, 1'b1);
      chk("mr_boot_idle", o_state, 4'd2);
      chk("mr_no_cfg_done", o_cfg_done, 1'b0);
      @(negedge clk);
      chk("mr_stays_idle", o_state, 4'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/adc_spi_sched.md
ADC_SPI_SCHED -- requirements
Module: adc_spi_sched

Interface
REQ-001 Parameters (name, default, meaning):
- P_TIMEOUT, 1000, max cycles to wait for i_spi_done.
- P_ENTER, 24'hBF_FF00, config-mode entry frame.
- P_EXIT, 24'h00_1401, config-mode exit frame.

REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock.
- i_rst, in, 1, reset; one clock, reset is asynchronous and active-high.
- i_rd_req, in, 1, one-cycle pulse from the sampling FSM requesting a data-read frame.
- o_rd_done, out, 1, one-cycle pulse when the data-read frame completes.
- o_rd_drop, out, 1, one-cycle pulse when a read request is discarded.
- o_drop_cnt, out, 8, saturating count of dropped reads.
- i_cfg_req, in, 1, one-cycle pulse requesting a register access.
- i_cfg_wr, in, 1, 1 = write, 0 = read.
- i_cfg_addr, in, 15, register address.
- i_cfg_wdata, in, 8, write data.
- o_cfg_busy, out, 1, config request pending or in progress.
- o_cfg_done, out, 1, one-cycle pulse when the config sequence ends.
- o_cfg_err, out, 1, valid with o_cfg_done; 1 = timeout.
- o_cfg_rdata, out, 8, register read data.
- o_spi_start, out, 1, one-cycle SPI launch.
- o_spi_mode, out, 1, 0 = CPOL/CPHA 00 data read, 1 = CPOL/CPHA 01 register.
- o_spi_tx, out, 24, frame to shift.
- i_spi_done, in, 1, one-cycle SPI completion pulse.
- i_spi_rx, in, 8, last received byte.
- o_timeout, out, 1, one-cycle pulse on any SPI timeout.
- o_state, out, 4, current FSM state.

Function
REQ-003 FSM state encoding: RST_EXIT=0, RST_WAIT=1, IDLE=2, RD_START=3, RD_WAIT=4, ENT_START=5, ENT_WAIT=6, ACC_START=7, ACC_WAIT=8, EXT_START=9, EXT_WAIT=10, CFG_END=11.
REQ-004 After reset, the FSM shall issue P_EXIT (RST_EXIT to RST_WAIT), so the ADC is left in conversion mode, then go to IDLE on i_spi_done.
REQ-005 IDLE transitions:
- i_rd_req high: go to RD_START.
- Otherwise, if a config request is pending: go to ENT_START.
- Reads always have priority.
REQ-006 o_spi_start shall be high for exactly the one cycle spent in each *_START state; the next state is the matching *_WAIT.
REQ-007 o_spi_tx and o_spi_mode shall be registered, valid in the *_START cycle, and stable until leaving *_WAIT. Per state:
- RD: mode 0, tx 0.
- ENT, EXT, RST: mode 1, tx P_ENTER or P_EXIT.
- ACC: mode 1, tx = {~i_cfg_wr, addr, wr ? wdata : 8'h00} using the latched request.
REQ-008 Each *_WAIT state shall advance on i_spi_done:
- RD_WAIT to IDLE.
- ENT_WAIT to ACC_START.
- ACC_WAIT to EXT_START.
- EXT_WAIT to CFG_END.
- CFG_END to IDLE after one cycle.
REQ-009 o_rd_done shall pulse in the cycle after i_spi_done is sampled in RD_WAIT, so RD_START to o_rd_done is (SPI length + 2) cycles.
REQ-010 i_cfg_req handling:
- While o_cfg_busy is low, i_cfg_req latches wr, addr and wdata and sets o_cfg_busy next cycle.
- While o_cfg_busy is high, i_cfg_req is ignored.
- o_cfg_busy clears in the cycle o_cfg_done pulses.
REQ-011 On a config read, o_cfg_rdata shall capture i_spi_rx on i_spi_done in ACC_WAIT and hold until the next config read capture; writes shall not alter it.
REQ-012 o_cfg_done shall pulse in CFG_END, with o_cfg_err = 0 on normal completion.
REQ-013 i_rd_req received in any state other than IDLE shall be dropped:
- o_rd_drop pulses the next cycle.
- o_drop_cnt increments and saturates at 255.
- Same-cycle i_cfg_req is still latched.
REQ-014 Timeout: a wait counter counts cycles in each *_WAIT state and clears on state change. When it reaches P_TIMEOUT-1 without i_spi_done:
- o_timeout pulses.
- From RD_WAIT: go to IDLE, with no o_rd_done.
- From ENT/ACC_WAIT: go to EXT_START, to still exit config mode.
- From EXT_WAIT: go to CFG_END with o_cfg_err = 1.
- From RST_WAIT: go to IDLE.
- An o_cfg_err set by an earlier timeout persists to CFG_END.
REQ-015 i_spi_done outside *_WAIT states shall be ignored.
REQ-016 Simultaneous i_spi_done and timeout in the same cycle: i_spi_done wins.

Reset
REQ-017 i_rst high shall immediately set:
- state = RST_EXIT.
- All pulses, o_cfg_busy, o_cfg_err, o_drop_cnt, o_cfg_rdata = 0.
- o_spi_tx = 0, o_spi_mode = 0.
- Pending request cleared.
Reset mid-frame abandons the frame, with no done pulse; REQ-004 then runs.

Verification
REQ-018 Reset release, i_spi_done 30 cycles after start -> one start with tx=24'h00_1401, mode 1; then o_state=2.
REQ-019 i_rd_req in IDLE, done after 25 cycles -> start with tx 0, mode 0; o_rd_done 27 cycles after the start cycle.
REQ-020 Config read, addr 0x0020, rx=8'h80 -> frames BF_FF00, 80_2000, 00_1401; then o_cfg_rdata=8'h80, o_cfg_done with o_cfg_err=0.
REQ-021 i_cfg_req and i_rd_req in the same IDLE cycle -> read frame first, then config sequence; i_rd_req during ACC_WAIT -> o_rd_drop, o_drop_cnt=1.
REQ-022 Config write, done withheld in ACC_WAIT -> o_timeout after P_TIMEOUT cycles, EXT frame still issued, o_cfg_done with o_cfg_err=1.
REQ-023 300 dropped reads -> o_drop_cnt=255; i_rst mid-ACC_WAIT -> o_cfg_busy=0 immediately, o_state=0.
